// File: rtl/pattern_link_pkg.sv
// Shared definitions for the serial pattern link: transmitter state encoding
// and the default sync word also used by the receive-side detector.
package pattern_link_pkg;

    localparam logic ST_IDLE_ENC = 1'b0;
    localparam logic ST_SEND_ENC = 1'b1;

    typedef enum logic {
        IDLE = ST_IDLE_ENC,
        SEND = ST_SEND_ENC
    } tx_state_t;

    localparam int              SYNC_W_DEF = 4;
    localparam logic [3:0]      SYNC_DEF   = 4'b0011;

endpackage

// File: rtl/pattern_serial_tx_if.sv
// Load/serial bundle between the stimulus side (master) and the pattern transmitter (slave).
interface pattern_serial_tx_if #(
    parameter int PAT_W = 20
);
    localparam int LEN_W = $clog2(PAT_W + 1);

    logic             ld_valid;
    logic             ld_ready;
    logic [PAT_W-1:0] ld_pattern;
    logic [LEN_W-1:0] ld_len;
    logic             ld_repeat;
    logic             stop;
    logic             bit_out;
    logic             bit_stb;
    logic             busy;
    logic             frame_done;
    logic             exp_hit;
    logic [7:0]       hit_cnt;

    modport master (
        output ld_valid, ld_pattern, ld_len, ld_repeat, stop,
        input  ld_ready, bit_out, bit_stb, busy, frame_done, exp_hit, hit_cnt
    );

    modport slave (
        input  ld_valid, ld_pattern, ld_len, ld_repeat, stop,
        output ld_ready, bit_out, bit_stb, busy, frame_done, exp_hit, hit_cnt
    );

endinterface

// File: rtl/pattern_serial_tx_bit_tick_gen.sv
// Bit-period counter: counts DIV clocks while enabled and flags the last one.
module bit_tick_gen #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int              CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] TC   = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tick = en && (cnt_q == TC);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pattern_serial_tx.sv
// Serial pattern transmitter: shifts a loaded pattern out LSB first, one bit per DIV
// clocks, and predicts sync-word hits for checking the downstream detector.
//
//  state | meaning
//  IDLE  | waiting for a load; bit_out parked at IDLE_BIT, ld_ready high
//  SEND  | shifting the latched pattern; wraps seamlessly while repeat is latched
module pattern_serial_tx
    import pattern_link_pkg::*;
#(
    parameter int               PAT_W    = 20,
    parameter int               DIV      = 50000,
    parameter int               SYNC_W   = SYNC_W_DEF,
    parameter logic [SYNC_W-1:0] SYNC    = SYNC_DEF,
    parameter logic             IDLE_BIT = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    pattern_serial_tx_if.slave   bus
);
    localparam int               LEN_W    = $clog2(PAT_W + 1);
    localparam int               FILL_W   = $clog2(SYNC_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SYNC_W - 1);

    tx_state_t         state_q, state_d;
    logic              accept, tick, last_bit, frame_end;
    logic [PAT_W-1:0]  pat_q;
    logic [LEN_W-1:0]  len_q, idx_q, idx_nxt, eff_len;
    logic              rep_q;
    logic [SYNC_W-2:0] hist_q;
    logic [FILL_W-1:0] fill_q;
    logic              send_bit, cur_bit, hit_now;
    logic              bit_out_q, bit_stb_q, frame_done_q, exp_hit_q;
    logic [7:0]        hit_cnt_q;

    assign bus.ld_ready   = (state_q == IDLE);
    assign bus.busy       = (state_q == SEND);
    assign bus.bit_out    = bit_out_q;
    assign bus.bit_stb    = bit_stb_q;
    assign bus.frame_done = frame_done_q;
    assign bus.exp_hit    = exp_hit_q;
    assign bus.hit_cnt    = hit_cnt_q;

    assign accept    = bus.ld_valid && (state_q == IDLE);
    assign last_bit  = (idx_q == len_q - LEN_W'(1));
    assign frame_end = tick && last_bit;

    bit_tick_gen #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .en    (state_q == SEND),
        .tick  (tick)
    );

    always_comb begin
        eff_len = bus.ld_len;
        if (bus.ld_len == '0 || bus.ld_len > LEN_W'(PAT_W)) begin
            eff_len = LEN_W'(PAT_W);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SEND;
            SEND:    if (frame_end && !rep_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A fresh load starts with an empty history, so no hit is possible until
    // SYNC_W real bits have gone out.
    always_comb begin
        send_bit = 1'b0;
        idx_nxt  = idx_q;
        if (accept) begin
            send_bit = 1'b1;
            idx_nxt  = '0;
        end else if (tick) begin
            if (!last_bit) begin
                send_bit = 1'b1;
                idx_nxt  = idx_q + LEN_W'(1);
            end else if (rep_q) begin
                send_bit = 1'b1;
                idx_nxt  = '0;
            end
        end
        cur_bit = accept ? bus.ld_pattern[0] : pat_q[idx_nxt];
        hit_now = send_bit && !accept && (fill_q == FILL_MAX) && ({hist_q, cur_bit} == SYNC);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q        <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            rep_q        <= 1'b0;
            hist_q       <= '0;
            fill_q       <= '0;
            bit_out_q    <= IDLE_BIT;
            bit_stb_q    <= 1'b0;
            frame_done_q <= 1'b0;
            exp_hit_q    <= 1'b0;
            hit_cnt_q    <= '0;
        end else begin
            bit_stb_q    <= send_bit;
            exp_hit_q    <= hit_now;
            frame_done_q <= frame_end && !rep_q;
            if (accept) begin
                pat_q     <= bus.ld_pattern;
                len_q     <= eff_len;
                rep_q     <= bus.ld_repeat;
                idx_q     <= '0;
                bit_out_q <= bus.ld_pattern[0];
                hist_q    <= (SYNC_W-1)'(bus.ld_pattern[0]);
                fill_q    <= FILL_W'(1);
                hit_cnt_q <= '0;
            end else if (state_q == SEND) begin
                if (bus.stop) rep_q <= 1'b0;
                if (send_bit) begin
                    idx_q     <= idx_nxt;
                    bit_out_q <= cur_bit;
                    hist_q    <= (SYNC_W-1)'({hist_q, cur_bit});
                    if (fill_q != FILL_MAX) fill_q <= fill_q + FILL_W'(1);
                    if (hit_now && hit_cnt_q != 8'hFF) hit_cnt_q <= hit_cnt_q + 8'd1;
                end else if (frame_end) begin
                    bit_out_q <= IDLE_BIT;
                end
            end
        end
    end

endmodule

// File: tb/tb_pattern_serial_tx.sv
// Self-checking bench for pattern_serial_tx with DIV=4, using a per-cycle
// expectation table built from the bit-timing and sync-word rules.
module tb_pattern_serial_tx;
    import pattern_link_pkg::*;

    localparam int PAT_W = 20;
    localparam int DIV   = 4;
    localparam int LEN_W = $clog2(PAT_W + 1);
    localparam int MAXC  = 5000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pattern_serial_tx_if #(.PAT_W(PAT_W)) bus();

    pattern_serial_tx #(
        .PAT_W(PAT_W), .DIV(DIV), .SYNC_W(4), .SYNC(4'b0011), .IDLE_BIT(1'b0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // {ld_ready, busy, bit_stb, bit_out, exp_hit, frame_done, hit_cnt}
    logic [13:0] e_vec [MAXC];
    int          e_end;

    localparam logic [13:0] IDLE_VEC = 14'b1_0_0_0_0_0_00000000;

    function automatic logic [13:0] obs();
        return {bus.ld_ready, bus.busy, bus.bit_stb, bus.bit_out,
                bus.exp_hit, bus.frame_done, bus.hit_cnt};
    endfunction

    function automatic int eff_len(input int len);
        return (len == 0 || len > PAT_W) ? PAT_W : len;
    endfunction

    // Frames sent when stop is pulsed in SEND cycle cs of a repeating load.
    function automatic int n_frames(input int len, input bit rep, input int cs);
        if (!rep) return 1;
        return cs / (eff_len(len) * DIV) + 1;
    endfunction

    task automatic build_expected(input logic [PAT_W-1:0] pat, input int len, input int nf);
        int   L, k, hits;
        bit   seq[$];
        logic stb, b, hit;
        logic [3:0] w;
        L     = eff_len(len);
        hits  = 0;
        e_end = 1 + nf * L * DIV;
        for (int c = 1; c <= e_end; c++) begin
            if (c == e_end) begin
                e_vec[c] = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'((hits > 255) ? 255 : hits)};
            end else begin
                k   = (c - 1) / DIV;
                stb = ((c - 1) % DIV) == 0;
                b   = pat[k % L];
                hit = 1'b0;
                if (stb) begin
                    seq.push_back(b);
                    if (k >= 3) begin
                        w   = {seq[k-3], seq[k-2], seq[k-1], seq[k]};
                        hit = (w == 4'b0011);
                    end
                    if (hit) hits++;
                end
                e_vec[c] = {1'b0, 1'b1, stb, b, hit, 1'b0, 8'((hits > 255) ? 255 : hits)};
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_load(input logic [PAT_W-1:0] pat, input int len, input bit rep);
        bus.ld_valid   = 1'b1;
        bus.ld_pattern = pat;
        bus.ld_len     = LEN_W'(len);
        bus.ld_repeat  = rep;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.stop = 1'b0;
        drive_load(PAT_W'($urandom), 5, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs() !== IDLE_VEC) begin
                errors++;
                $display("FAIL reset_hold i=%0d got %h exp %h", i, obs(), IDLE_VEC);
            end
        end
        reset = 1'b0;
        bus.ld_valid = 1'b0;
        step();
        checks++;
        if (obs() !== IDLE_VEC) begin
            errors++;
            $display("FAIL reset_release got %h exp %h", obs(), IDLE_VEC);
        end
    endtask

    task automatic test_single();
        logic [PAT_W-1:0] pat;
        pat = 20'b11001000010110110111;
        drive_load(pat, 20, 1'b0);
        checks++;
        if (bus.ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_ready got %b exp 1", bus.ld_ready);
        end
        build_expected(pat, 20, 1);
        for (int c = 1; c <= e_end; c++) begin
            step();
            if (c == 1) bus.ld_valid = 1'b0;
            checks++;
            if (obs() !== e_vec[c]) begin
                errors++;
                $display("FAIL single c=%0d got %h exp %h", c, obs(), e_vec[c]);
            end
        end
        step();
        checks++;
        if (obs() !== 14'b1_0_0_0_0_0_00000001) begin
            errors++;
            $display("FAIL single_after got %h exp %h", obs(), 14'b1_0_0_0_0_0_00000001);
        end
    endtask

    task automatic test_repeat_stop();
        logic [PAT_W-1:0] pat;
        pat = 20'b11001000010110110111;
        drive_load(pat, 20, 1'b1);
        build_expected(pat, 20, n_frames(20, 1'b1, 90));
        for (int c = 1; c <= e_end; c++) begin
            step();
            if (c == 1) bus.ld_valid = 1'b0;
            bus.stop = (c == 90);
            checks++;
            if (obs() !== e_vec[c]) begin
                errors++;
                $display("FAIL repeat_stop c=%0d got %h exp %h", c, obs(), e_vec[c]);
            end
        end
        bus.stop = 1'b0;
        step();
        checks++;
        if (obs() !== 14'b1_0_0_0_0_0_00000010) begin
            errors++;
            $display("FAIL repeat_stop_after got %h exp %h", obs(), 14'b1_0_0_0_0_0_00000010);
        end
    endtask

    task automatic test_overlap();
        logic [PAT_W-1:0] pat;
        pat = {12'($urandom), 8'b11001100};
        drive_load(pat, 8, 1'b0);
        build_expected(pat, 8, 1);
        for (int c = 1; c <= e_end; c++) begin
            step();
            if (c == 1) bus.ld_valid = 1'b0;
            checks++;
            if (obs() !== e_vec[c]) begin
                errors++;
                $display("FAIL overlap c=%0d got %h exp %h", c, obs(), e_vec[c]);
            end
        end
        checks++;
        if (bus.hit_cnt !== 8'd2) begin
            errors++;
            $display("FAIL overlap_cnt got %0d exp 2", bus.hit_cnt);
        end
    endtask

    task automatic test_len_zero_hold();
        logic [PAT_W-1:0] pat;
        pat = PAT_W'($urandom);
        drive_load(pat, 0, 1'b0);
        build_expected(pat, 0, 1);
        for (int c = 1; c <= e_end; c++) begin
            step();
            checks++;
            if (obs() !== e_vec[c]) begin
                errors++;
                $display("FAIL len_zero_hold c=%0d got %h exp %h", c, obs(), e_vec[c]);
            end
            if (c < e_end) drive_load(PAT_W'($urandom), $urandom_range(0, 31), 1'($urandom));
            else bus.ld_valid = 1'b0;
        end
        step();
        checks++;
        if (bus.busy !== 1'b0 || bus.bit_stb !== 1'b0) begin
            errors++;
            $display("FAIL len_zero_idle got busy=%b stb=%b exp busy=0 stb=0", bus.busy, bus.bit_stb);
        end
    endtask

    task automatic test_reset_mid();
        logic [PAT_W-1:0] pat, pat_b;
        int               len_b;
        pat = {PAT_W'($urandom)} & ~PAT_W'(4'hF) | PAT_W'(4'b1100);
        drive_load(pat, 20, 1'b1);
        build_expected(pat, 20, 1);
        for (int c = 1; c <= 30; c++) begin
            step();
            if (c == 1) bus.ld_valid = 1'b0;
            checks++;
            if (obs() !== e_vec[c]) begin
                errors++;
                $display("FAIL reset_mid c=%0d got %h exp %h", c, obs(), e_vec[c]);
            end
        end
        reset = 1'b1;
        drive_load(PAT_W'($urandom), 3, 1'b0);
        step();
        checks++;
        if (obs() !== IDLE_VEC) begin
            errors++;
            $display("FAIL reset_mid_clear got %h exp %h", obs(), IDLE_VEC);
        end
        reset = 1'b0;
        pat_b = PAT_W'($urandom);
        len_b = $urandom_range(1, 10);
        drive_load(pat_b, len_b, 1'b0);
        build_expected(pat_b, len_b, 1);
        for (int c = 1; c <= e_end; c++) begin
            step();
            if (c == 1) bus.ld_valid = 1'b0;
            checks++;
            if (obs() !== e_vec[c]) begin
                errors++;
                $display("FAIL reset_mid_reload c=%0d got %h exp %h", c, obs(), e_vec[c]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [PAT_W-1:0] pat_a, pat_b;
        int               len_a, len_b;
        pat_a = PAT_W'($urandom);
        pat_b = PAT_W'($urandom);
        len_a = $urandom_range(1, 8);
        len_b = $urandom_range(1, 8);
        drive_load(pat_a, len_a, 1'b0);
        build_expected(pat_a, len_a, 1);
        for (int c = 1; c <= e_end; c++) begin
            step();
            if (c == 1) drive_load(pat_b, len_b, 1'b0);
            checks++;
            if (obs() !== e_vec[c]) begin
                errors++;
                $display("FAIL b2b_first c=%0d got %h exp %h", c, obs(), e_vec[c]);
            end
        end
        build_expected(pat_b, len_b, 1);
        for (int c = 1; c <= e_end; c++) begin
            step();
            if (c == 1) bus.ld_valid = 1'b0;
            checks++;
            if (obs() !== e_vec[c]) begin
                errors++;
                $display("FAIL b2b_second c=%0d got %h exp %h", c, obs(), e_vec[c]);
            end
        end
    endtask

    // Stop lands exactly on a wrap decision cycle, and the hit count runs past 255.
    task automatic test_saturation();
        logic [PAT_W-1:0] pat;
        int               cs;
        pat = PAT_W'(4'b1100);
        cs  = 260 * 4 * DIV;
        drive_load(pat, 4, 1'b1);
        build_expected(pat, 4, n_frames(4, 1'b1, cs));
        for (int c = 1; c <= e_end; c++) begin
            step();
            if (c == 1) bus.ld_valid = 1'b0;
            bus.stop = (c == cs);
            checks++;
            if (obs() !== e_vec[c]) begin
                errors++;
                $display("FAIL saturation c=%0d got %h exp %h", c, obs(), e_vec[c]);
            end
        end
        bus.stop = 1'b0;
        checks++;
        if (bus.hit_cnt !== 8'd255) begin
            errors++;
            $display("FAIL saturation_cnt got %0d exp 255", bus.hit_cnt);
        end
    endtask

    task automatic test_random();
        logic [PAT_W-1:0] pat;
        int               len, cs;
        bit               rep;
        for (int it = 0; it < 6; it++) begin
            pat = PAT_W'($urandom);
            len = $urandom_range(0, 31);
            rep = 1'($urandom);
            cs  = $urandom_range(1, 2 * eff_len(len) * DIV + 5);
            step();
            drive_load(pat, len, rep);
            build_expected(pat, len, n_frames(len, rep, cs));
            for (int c = 1; c <= e_end; c++) begin
                step();
                if (c == 1) bus.ld_valid = 1'b0;
                bus.stop = (c == cs);
                checks++;
                if (obs() !== e_vec[c]) begin
                    errors++;
                    $display("FAIL random it=%0d c=%0d got %h exp %h", it, c, obs(), e_vec[c]);
                end
            end
            bus.stop = 1'b0;
        end
    endtask

    initial begin
        bus.ld_valid   = 1'b0;
        bus.ld_pattern = '0;
        bus.ld_len     = '0;
        bus.ld_repeat  = 1'b0;
        bus.stop       = 1'b0;
        test_reset();
        test_single();
        step();
        test_repeat_stop();
        step();
        test_overlap();
        step();
        test_len_zero_hold();
        step();
        test_reset_mid();
        step();
        test_back_to_back();
        step();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
